// File: rtl/fir_tone_source_pkg.sv
// Shared constants for the two-tone FIR characterisation source:
// sample/LUT widths, midscale and the quarter-wave sine table.
package fir_tone_source_pkg;

  localparam int unsigned SAMPLE_W     = 10;
  localparam int unsigned MIDSCALE     = 512;
  localparam int unsigned LUT_SAMPLE_W = 9;
  localparam int unsigned LUT_ADDR_W   = 8;
  localparam int unsigned QTR_ENTRIES  = 64;

  // Q[i] = round(255*sin(2*pi*(i+0.5)/256)); the half-step offset keeps the fold symmetric
  localparam logic [7:0] QUARTER_SINE [QTR_ENTRIES] = '{
    8'd3,   8'd9,   8'd16,  8'd22,  8'd28,  8'd34,  8'd41,  8'd47,
    8'd53,  8'd59,  8'd65,  8'd71,  8'd77,  8'd83,  8'd89,  8'd95,
    8'd100, 8'd106, 8'd112, 8'd117, 8'd123, 8'd128, 8'd134, 8'd139,
    8'd144, 8'd149, 8'd154, 8'd159, 8'd164, 8'd169, 8'd174, 8'd178,
    8'd183, 8'd187, 8'd191, 8'd195, 8'd199, 8'd203, 8'd207, 8'd210,
    8'd214, 8'd217, 8'd220, 8'd223, 8'd226, 8'd229, 8'd232, 8'd234,
    8'd237, 8'd239, 8'd241, 8'd243, 8'd245, 8'd247, 8'd248, 8'd249,
    8'd251, 8'd252, 8'd253, 8'd253, 8'd254, 8'd255, 8'd255, 8'd255
  };

endpackage

// File: rtl/fir_tone_source_if.sv
// Control and sample bus of the tone source; master is the source side.
interface fir_tone_source_if
  import fir_tone_source_pkg::*;
#(
  parameter int unsigned PHASE_W = 16
);
  logic                enable;
  logic                phase_clr;
  logic [PHASE_W-1:0]  freq1;
  logic [PHASE_W-1:0]  freq2;
  logic [SAMPLE_W-1:0] data_out;
  logic                data_valid;

  modport master (
    input  enable, phase_clr, freq1, freq2,
    output data_out, data_valid
  );

  modport slave (
    output enable, phase_clr, freq1, freq2,
    input  data_out, data_valid
  );
endinterface

// File: rtl/fir_tone_quarter_lut.sv
// Quarter-wave sine lookup with quadrant folding; one registered signed
// sample per cycle from an 8-bit phase address.
module fir_tone_quarter_lut
  import fir_tone_source_pkg::*;
(
  input  logic                                clk,
  input  logic                                reset_p,
  input  logic        [LUT_ADDR_W-1:0]        addr,
  output logic signed [LUT_SAMPLE_W-1:0]      sample
);

  logic        [5:0]              idx_c;
  logic        [7:0]              mag_c;
  logic signed [LUT_SAMPLE_W-1:0] fold_c;

  // Odd quadrants mirror the index; the upper half-cycle negates
  always_comb begin
    idx_c  = addr[6] ? ~addr[5:0] : addr[5:0];
    mag_c  = QUARTER_SINE[idx_c];
    fold_c = addr[7] ? -$signed({1'b0, mag_c}) : $signed({1'b0, mag_c});
  end

  always_ff @(posedge clk) begin
    if (reset_p) sample <= '0;
    else         sample <= fold_c;
  end

endmodule

// File: rtl/fir_tone_source.sv
// Two-tone DDS sample source feeding the FIR filters at clk/CLK_DIV.
// Define FIR_TONE_SOURCE_TONE2_EN to build the second tone.
module fir_tone_source
  import fir_tone_source_pkg::*;
#(
  parameter int unsigned CLK_DIV = 500,
  parameter int unsigned PHASE_W = 16
)(
  input logic             clk,
  input logic             reset_p,
  fir_tone_source_if.master bus
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned SUM_W = SAMPLE_W + 1;

  logic [CNT_W-1:0]               cnt;
  logic                           tick_c;
  logic [PHASE_W-1:0]             phase1;
  logic [LUT_ADDR_W-1:0]          addr1;
  logic signed [LUT_SAMPLE_W-1:0] s1;
  logic signed [LUT_SAMPLE_W-1:0] s2;
  logic                           v_addr;
  logic                           v_lut;
  logic [SUM_W-1:0]               sum_c;

  assign tick_c = bus.enable && (cnt == CNT_W'(CLK_DIV - 1));

  // Sample-rate counter, parked at zero while disabled
  always_ff @(posedge clk) begin
    if (reset_p)                    cnt <= '0;
    else if (!bus.enable || tick_c) cnt <= '0;
    else                            cnt <= cnt + 1'b1;
  end

  // Address capture uses the pre-update phase, so a clear on a tick still emits the old phase
  always_ff @(posedge clk) begin
    if (reset_p) begin
      phase1 <= '0;
      addr1  <= '0;
      v_addr <= 1'b0;
      v_lut  <= 1'b0;
    end else begin
      if (tick_c)             addr1  <= phase1[PHASE_W-1 -: LUT_ADDR_W];
      if (bus.phase_clr)      phase1 <= '0;
      else if (tick_c)        phase1 <= phase1 + bus.freq1;
      v_addr <= tick_c;
      v_lut  <= v_addr;
    end
  end

  fir_tone_quarter_lut u_lut1 (
    .clk     (clk),
    .reset_p (reset_p),
    .addr    (addr1),
    .sample  (s1)
  );

`ifdef FIR_TONE_SOURCE_TONE2_EN
  logic [PHASE_W-1:0]    phase2;
  logic [LUT_ADDR_W-1:0] addr2;

  always_ff @(posedge clk) begin
    if (reset_p) begin
      phase2 <= '0;
      addr2  <= '0;
    end else begin
      if (tick_c)        addr2  <= phase2[PHASE_W-1 -: LUT_ADDR_W];
      if (bus.phase_clr) phase2 <= '0;
      else if (tick_c)   phase2 <= phase2 + bus.freq2;
    end
  end

  fir_tone_quarter_lut u_lut2 (
    .clk     (clk),
    .reset_p (reset_p),
    .addr    (addr2),
    .sample  (s2)
  );
`else
  logic unused_freq2;
  assign unused_freq2 = ^bus.freq2;
  assign s2           = '0;
`endif

  // Both tones are within +-255, so the offset sum stays inside 2..1022
  assign sum_c = SUM_W'(MIDSCALE) + SUM_W'(s1) + SUM_W'(s2);

  always_ff @(posedge clk) begin
    if (reset_p) begin
      bus.data_out   <= SAMPLE_W'(MIDSCALE);
      bus.data_valid <= 1'b0;
    end else begin
      bus.data_valid <= v_lut;
      if (v_lut) bus.data_out <= sum_c[SAMPLE_W-1:0];
    end
  end

endmodule

// File: tb/tb_fir_tone_source.sv
// Randomised and directed bench for fir_tone_source against a sine-math
// reference model with a timed sample queue.
module tb_fir_tone_source;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned PHASE_W = 16;
  localparam real         PI      = 3.14159265358979323846;

`ifdef FIR_TONE_SOURCE_TONE2_EN
  localparam int EXP_Q [4] = '{518, 770, 512, 260};
`else
  localparam int EXP_Q [4] = '{515, 767, 509, 257};
`endif

  logic clk = 1'b0;
  logic reset_p;
  always #5 clk = ~clk;

  fir_tone_source_if #(.PHASE_W(PHASE_W)) bus ();

  fir_tone_source #(.CLK_DIV(CLK_DIV), .PHASE_W(PHASE_W)) dut (
    .clk     (clk),
    .reset_p (reset_p),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit                 exp_valid = 1'b0;
  int                 exp_data  = 512;
  int                 run       = 0;
  int                 rel       = 0;
  int                 cyc       = 0;
  logic [PHASE_W-1:0] ph1       = '0;
  logic [PHASE_W-1:0] ph2       = '0;
  int                 due_q[$];
  int                 val_q[$];
  int                 obs_rel[$];
  int                 obs_val[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int tone_sample(input logic [7:0] a);
    real v;
    v = 255.0 * $sin(2.0 * PI * (real'(a) + 0.5) / 256.0);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else          return -$rtoi(-v + 0.5);
  endfunction

  function automatic int obs_rel_at(input int i);
    return (i < obs_rel.size()) ? obs_rel[i] : -1;
  endfunction

  function automatic int obs_val_at(input int i);
    return (i < obs_val.size()) ? obs_val[i] : -1;
  endfunction

  task automatic clear_obs();
    obs_rel.delete();
    obs_val.delete();
  endtask

  // One clock: check this cycle's outputs, drive this cycle's inputs, predict the next cycle
  task automatic step(input bit rst, input bit en, input bit clr,
                      input logic [PHASE_W-1:0] f1, input logic [PHASE_W-1:0] f2);
    bit tick;
    int s;
    @(negedge clk);
    check_eq("data_valid", 32'(bus.data_valid), 32'(exp_valid));
    check_eq("data_out", 32'(bus.data_out), exp_data);
    if (bus.data_valid === 1'b1) begin
      obs_rel.push_back(rel);
      obs_val.push_back(int'(bus.data_out));
    end
    reset_p       = rst;
    bus.enable    = en;
    bus.phase_clr = clr;
    bus.freq1     = f1;
    bus.freq2     = f2;
    if (rst) begin
      due_q.delete();
      val_q.delete();
      ph1       = '0;
      ph2       = '0;
      run       = 0;
      exp_valid = 1'b0;
      exp_data  = 512;
    end else begin
      tick = en && ((run % int'(CLK_DIV)) == int'(CLK_DIV) - 1);
      run  = en ? run + 1 : 0;
      if (tick) begin
        s = 512 + tone_sample(ph1[PHASE_W-1 -: 8]);
`ifdef FIR_TONE_SOURCE_TONE2_EN
        s = s + tone_sample(ph2[PHASE_W-1 -: 8]);
`endif
        due_q.push_back(cyc + 3);
        val_q.push_back(s);
      end
      if (clr) begin
        ph1 = '0;
        ph2 = '0;
      end else if (tick) begin
        ph1 = ph1 + f1;
        ph2 = ph2 + f2;
      end
      exp_valid = 1'b0;
      if (due_q.size() > 0 && due_q[0] == cyc + 1) begin
        exp_valid = 1'b1;
        exp_data  = val_q.pop_front();
        void'(due_q.pop_front());
      end
    end
    rel = rst ? 0 : rel + 1;
    cyc++;
  endtask

  initial begin
    bit rst, en, clr;
    logic [PHASE_W-1:0] f1, f2;
    reset_p       = 1'b1;
    bus.enable    = 1'b0;
    bus.phase_clr = 1'b0;
    bus.freq1     = '0;
    bus.freq2     = '0;
    repeat (2) @(posedge clk);

    // DC: both tones at phase 0
    step(1, 0, 0, 0, 0);
    clear_obs();
    for (int k = 0; k < 16; k++) step(0, 1, 0, 0, 0);
    check_eq("dc_first_cycle", obs_rel_at(0), 6);
    check_eq("dc_spacing", obs_rel_at(1) - obs_rel_at(0), 4);
    check_eq("dc_count", obs_val.size(), 3);
    check_eq("dc_value", obs_val_at(2), EXP_Q[0]);

    // Quarter-cycle step on tone 1
    step(1, 0, 0, 0, 0);
    clear_obs();
    for (int k = 0; k < 20; k++) step(0, 1, 0, 16'd16384, 0);
    for (int i = 0; i < 4; i++) check_eq($sformatf("quad_seq%0d", i), obs_val_at(i), EXP_Q[i]);

    // Phase clear on the tick that emits the second quadrant
    step(1, 0, 0, 0, 0);
    clear_obs();
    for (int k = 0; k < 20; k++) step(0, 1, k == 7, 16'd16384, 0);
    check_eq("clr_same_tick", obs_val_at(1), EXP_Q[1]);
    check_eq("clr_restart", obs_val_at(2), EXP_Q[0]);
    check_eq("clr_after", obs_val_at(3), EXP_Q[1]);

    // Reset one cycle after a tick discards the in-flight sample
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    clear_obs();
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    check_eq("rst_dout_mid", 32'(bus.data_out), 512);
    for (int k = 0; k < 10; k++) step(0, 1, 0, 0, 0);
    check_eq("rst_first_cycle", obs_rel_at(0), 6);
    check_eq("rst_count", obs_val.size(), 2);

    // Enable dropped one cycle after a tick: only the in-flight sample emerges
    step(1, 0, 0, 0, 0);
    clear_obs();
    for (int k = 0; k < 4; k++) step(0, 1, 0, 0, 0);
    for (int k = 0; k < 12; k++) step(0, 0, 0, 0, 0);
    check_eq("dis_count", obs_val.size(), 1);
    check_eq("dis_cycle", obs_rel_at(0), 6);
    check_eq("dis_hold", 32'(bus.data_out), EXP_Q[0]);

    // Random traffic
    step(1, 0, 0, 0, 0);
    f1 = 16'($urandom);
    f2 = 16'($urandom);
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 249) == 0);
      en  = ($urandom_range(0, 19) != 0);
      clr = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 11) == 0) begin
        f1 = 16'($urandom);
        f2 = 16'($urandom);
      end
      step(rst, en, clr, f1, f2);
    end
    step(0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
